// File: rtl/wavelet_readout_scheduler.sv
// wavelet_readout_scheduler
//
// Frame-based readout scheduler for a chain of wavelet cores. Each core
// reports 2-bit I and Q feedback events that are integrated as signed
// up/down counts over a frame of FRAME_LEN enabled cycles. At frame end all
// counts are snapshotted and streamed out one word per handshake, in the
// order core0 I, core0 Q, core1 I, ... on a valid/ready port.
//
// Optional feature: define READOUT_SATURATE_EN to make the accumulators
// clamp at their signed bounds instead of wrapping modulo 2^ACC_W.
//
// Ports:
//   clk_master  sole clock, rising edge
//   rst         asynchronous active-high reset
//   ud_en       integration enable, common to all cores
//   read_out_I  per-core I events; bit 2k = +1, bit 2k+1 = -1
//   read_out_Q  per-core Q events, same encoding
//   out_data    signed count of the current word
//   out_core    core index of the current word
//   out_q       0 = I channel, 1 = Q channel
//   out_last    high on the final word of a frame
//   out_valid   word available
//   out_ready   consumer accepts the word when out_valid & out_ready
//   frame_tick  one-cycle pulse in the cycle after each frame end
//   overrun     sticky: a frame ended while the previous one was draining
module wavelet_readout_scheduler #(
  parameter int NCORES    = 8,
  parameter int ACC_W     = 12,
  parameter int FRAME_LEN = 1024,
  localparam int CORE_W   = (NCORES > 1) ? $clog2(NCORES) : 1
) (
  input  logic                clk_master,
  input  logic                rst,
  input  logic                ud_en,
  input  logic [2*NCORES-1:0] read_out_I,
  input  logic [2*NCORES-1:0] read_out_Q,
  output logic [ACC_W-1:0]    out_data,
  output logic [CORE_W-1:0]   out_core,
  output logic                out_q,
  output logic                out_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                frame_tick,
  output logic                overrun
);

  localparam int NCH   = 2 * NCORES;
  localparam int IDX_W = $clog2(NCH);
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc     [NCH];
  logic signed [ACC_W-1:0] acc_upd [NCH];
  logic signed [ACC_W-1:0] shadow  [NCH];
  logic                    frame_end;
  logic                    handshake;
  logic                    snap;
  logic                    overrun_set;

  // Apply one 2-bit event sample to an accumulator: 01 counts up, 10 counts
  // down, 00 and 11 cancel out.
  function automatic logic signed [ACC_W-1:0] add_delta(
    input logic signed [ACC_W-1:0] a,
    input logic [1:0]              s
  );
    logic signed [ACC_W-1:0] d;
`ifdef READOUT_SATURATE_EN
    logic [ACC_W:0] sum;
`endif
    case (s)
      2'b01:   d = ACC_W'(1);
      2'b10:   d = '1;
      default: d = '0;
    endcase
`ifdef READOUT_SATURATE_EN
    // One extra bit exposes overflow; when the top two bits disagree the
    // result left the representable range and is pinned to the bound.
    sum = {a[ACC_W-1], a} + {d[ACC_W-1], d};
    if (sum[ACC_W] != sum[ACC_W-1])
      return sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      return sum[ACC_W-1:0];
`else
    return a + d;
`endif
  endfunction

  // Candidate accumulator values including this cycle's sample; channel
  // 2k is core k's I, channel 2k+1 is core k's Q, matching output order.
  always_comb begin
    for (int k = 0; k < NCORES; k++) begin
      acc_upd[2*k]   = add_delta(acc[2*k],   read_out_I[2*k +: 2]);
      acc_upd[2*k+1] = add_delta(acc[2*k+1], read_out_Q[2*k +: 2]);
    end
  end

  // Serializer next state and output decode. The handshake is resolved
  // first so that a frame end coinciding with the last-word handshake sees
  // the serializer as already idle and takes the new snapshot.
  always_comb begin
    handshake   = (state == SEND) && out_ready;
    frame_end   = ud_en && (cnt == CNT_END);
    state_nxt   = state;
    idx_nxt     = idx;
    snap        = 1'b0;
    overrun_set = 1'b0;

    if (handshake) begin
      if (idx == LAST_IDX) begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end else begin
        idx_nxt = idx + 1'b1;
      end
    end

    if (frame_end) begin
      if (state_nxt == IDLE) begin
        snap      = 1'b1;
        state_nxt = SEND;
        idx_nxt   = '0;
      end else begin
        overrun_set = 1'b1;
      end
    end

    out_valid = (state == SEND);
    out_last  = (state == SEND) && (idx == LAST_IDX);
    out_data  = shadow[idx];
    out_core  = CORE_W'(idx >> 1);
    out_q     = idx[0];
  end

  // Serializer state, frame pulse and sticky overrun flag.
  always_ff @(posedge clk_master or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      frame_tick <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      frame_tick <= frame_end;
      overrun    <= overrun | overrun_set;
    end
  end

  // Frame counter and accumulators advance only on enabled cycles; the
  // shadow copy is loaded only when the serializer can accept a new frame.
  always_ff @(posedge clk_master or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      for (int c = 0; c < NCH; c++) begin
        acc[c]    <= '0;
        shadow[c] <= '0;
      end
    end else begin
      if (ud_en) begin
        cnt <= frame_end ? '0 : cnt + 1'b1;
        for (int c = 0; c < NCH; c++)
          acc[c] <= frame_end ? '0 : acc_upd[c];
      end
      if (snap) begin
        for (int c = 0; c < NCH; c++)
          shadow[c] <= acc_upd[c];
      end
    end
  end

endmodule

// File: tb/tb_wavelet_readout_scheduler.sv
// tb_wavelet_readout_scheduler
//
// Self-checking bench for wavelet_readout_scheduler with NCORES=2, ACC_W=4,
// FRAME_LEN=8. A transaction-level reference model keeps integer channel
// sums and a queue of words still owed to the consumer; every cycle the
// DUT outputs are compared against the head of that queue. Honours
// READOUT_SATURATE_EN the same way the design does.
module tb_wavelet_readout_scheduler;

  localparam int NC = 2;
  localparam int AW = 4;
  localparam int FL = 8;

  logic          clk_master = 1'b0;
  logic          rst;
  logic          ud_en;
  logic [2*NC-1:0] read_out_I;
  logic [2*NC-1:0] read_out_Q;
  logic [AW-1:0] out_data;
  logic          out_core;
  logic          out_q;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic          frame_tick;
  logic          overrun;

  wavelet_readout_scheduler #(.NCORES(NC), .ACC_W(AW), .FRAME_LEN(FL)) dut (
    .clk_master (clk_master),
    .rst        (rst),
    .ud_en      (ud_en),
    .read_out_I (read_out_I),
    .read_out_Q (read_out_Q),
    .out_data   (out_data),
    .out_core   (out_core),
    .out_q      (out_q),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_tick (frame_tick),
    .overrun    (overrun)
  );

  always #5 clk_master = ~clk_master;

  typedef struct {
    int data;
    int core;
    int q;
    int last;
  } word_t;

  word_t expQ[$];
  int    macc[2*NC];
  int    mcnt;
  int    movr;
  int    mtick;
  int    checks;
  int    errors;

  // Reduce an unbounded integer sum to its ACC_W-bit two's complement value.
  function automatic int wrapVal(input int v);
    int m;
    m = ((v % 16) + 16) % 16;
    return (m > 7) ? m - 16 : m;
  endfunction

  function automatic int deltaOf(input logic [1:0] s);
    if (s == 2'b01) return 1;
    if (s == 2'b10) return -1;
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Advance the reference model by one rising edge using the inputs that
  // were presented to the DUT for that edge.
  task automatic modelEdge();
    word_t w;
    logic [1:0] s;
    if (expQ.size() > 0 && out_ready) w = expQ.pop_front();
    mtick = 0;
    if (ud_en) begin
      for (int ch = 0; ch < 2*NC; ch++) begin
        s = (ch % 2) ? read_out_Q[2*(ch/2) +: 2] : read_out_I[2*(ch/2) +: 2];
        macc[ch] += deltaOf(s);
`ifdef READOUT_SATURATE_EN
        if (macc[ch] > 7)  macc[ch] = 7;
        if (macc[ch] < -8) macc[ch] = -8;
`endif
      end
      mcnt++;
      if (mcnt == FL) begin
        mcnt  = 0;
        mtick = 1;
        if (expQ.size() == 0) begin
          for (int ch = 0; ch < 2*NC; ch++)
            expQ.push_back('{wrapVal(macc[ch]), ch / 2, ch % 2, int'(ch == 2*NC-1)});
        end else begin
          movr = 1;
        end
        for (int ch = 0; ch < 2*NC; ch++) macc[ch] = 0;
      end
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_valid"}, int'(out_valid), int'(expQ.size() > 0));
    if (expQ.size() > 0) begin
      checkOutput({tag, "_data"}, int'($signed(out_data)), expQ[0].data);
      checkOutput({tag, "_core"}, int'(out_core), expQ[0].core);
      checkOutput({tag, "_q"},    int'(out_q),    expQ[0].q);
      checkOutput({tag, "_last"}, int'(out_last), expQ[0].last);
    end
    checkOutput({tag, "_tick"},    int'(frame_tick), mtick);
    checkOutput({tag, "_overrun"}, int'(overrun),    movr);
  endtask

  // Present one cycle of inputs, let the edge happen, update the model and
  // compare shortly after the edge.
  task automatic applyStimulus(input logic en, input logic [2*NC-1:0] i_bits,
                               input logic [2*NC-1:0] q_bits, input logic rdy,
                               input string tag);
    ud_en      = en;
    read_out_I = i_bits;
    read_out_Q = q_bits;
    out_ready  = rdy;
    @(posedge clk_master);
    modelEdge();
    #1;
    checkAll(tag);
  endtask

  // Asynchronous reset applied away from the clock edge; outputs must clear
  // immediately and stay clear across an edge while reset is held.
  task automatic doReset(input string tag);
    rst = 1'b1;
    ud_en = 1'b0;
    out_ready = 1'b0;
    read_out_I = '0;
    read_out_Q = '0;
    #1;
    expQ.delete();
    for (int ch = 0; ch < 2*NC; ch++) macc[ch] = 0;
    mcnt = 0;
    movr = 0;
    mtick = 0;
    checkOutput({tag, "_rst_data"}, int'(out_data), 0);
    checkOutput({tag, "_rst_core"}, int'(out_core), 0);
    checkOutput({tag, "_rst_q"},    int'(out_q), 0);
    checkOutput({tag, "_rst_last"}, int'(out_last), 0);
    checkAll({tag, "_rst"});
    @(posedge clk_master);
    #1;
    checkAll({tag, "_rsthold"});
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    ud_en = 1'b0;
    out_ready = 1'b0;
    read_out_I = '0;
    read_out_Q = '0;

    doReset("init");

    // Constant core0 I up-events and core1 Q down-events over one frame.
    for (int n = 0; n < FL; n++) applyStimulus(1'b1, 4'b0001, 4'b1000, 1'b1, "const");
`ifdef READOUT_SATURATE_EN
    checkOutput("const_w0", int'($signed(out_data)), 7);
`else
    checkOutput("const_w0", int'($signed(out_data)), -8);
`endif
    for (int n = 0; n < 2*NC + 1; n++) applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, "const_drain");

    // Alternating 01/11/10/00 on core0 I nets to zero.
    for (int n = 0; n < FL; n++) begin
      case (n % 4)
        0: applyStimulus(1'b1, 4'b0001, 4'b0000, 1'b1, "alt");
        1: applyStimulus(1'b1, 4'b0011, 4'b0000, 1'b1, "alt");
        2: applyStimulus(1'b1, 4'b0010, 4'b0000, 1'b1, "alt");
        default: applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1, "alt");
      endcase
    end
    checkOutput("alt_w0", int'($signed(out_data)), 0);
    for (int n = 0; n < 2*NC + 1; n++) applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, "alt_drain");

    // Enable dropped for 5 cycles mid-frame; those samples must not count.
    for (int n = 0; n < 3; n++) applyStimulus(1'b1, 4'b0001, 4'b0000, 1'b1, "gap_a");
    for (int n = 0; n < 5; n++) applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b1, "gap_off");
    for (int n = 0; n < 5; n++) applyStimulus(1'b1, 4'b0001, 4'b0000, 1'b1, "gap_b");
`ifdef READOUT_SATURATE_EN
    checkOutput("gap_w0", int'($signed(out_data)), 7);
`else
    checkOutput("gap_w0", int'($signed(out_data)), -8);
`endif
    for (int n = 0; n < 2*NC + 1; n++) applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, "gap_drain");

    // Consumer stalled across two frame ends, then released.
    for (int n = 0; n < 2*FL + 4; n++)
      applyStimulus(1'b1, 4'b0100, 4'b0001, 1'b0, "stall");
    checkOutput("stall_overrun", int'(overrun), 1);
    for (int n = 0; n < 2*NC + 1; n++) applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, "stall_drain");

    // Reset while the third word of a drain is on the port.
    doReset("mid");
    for (int n = 0; n < FL; n++) applyStimulus(1'b1, 4'b0001, 4'b0010, 1'b1, "mid_frame");
    for (int n = 0; n < 2; n++) applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, "mid_word");
    checkOutput("mid_idx_core", int'(out_core), 1);
    doReset("mid");
    for (int n = 0; n < FL; n++) applyStimulus(1'b1, 4'b0001, 4'b0000, 1'b1, "after_rst");
`ifdef READOUT_SATURATE_EN
    checkOutput("after_rst_w0", int'($signed(out_data)), 7);
`else
    checkOutput("after_rst_w0", int'($signed(out_data)), -8);
`endif

    // Random traffic: sparse enable gaps, random events, bursty consumer.
    for (int n = 0; n < 400; n++)
      applyStimulus(logic'($urandom_range(0, 9) < 8), 4'($urandom), 4'($urandom),
                    logic'($urandom_range(0, 9) < 7), "rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wavelet_readout_scheduler.md
# wavelet_readout_scheduler

Frame-based readout scheduler for a chain of `NCORES` wavelet cores. It samples each core's 2-bit I and Q feedback readout on every `clk_master` edge while `ud_en` is high, and integrates each channel as a signed up/down count over a fixed frame. At frame end it snapshots all counts and streams them out one word at a time on a valid/ready port. It sits between the wavelet-core array and the chip-level readout/logic-analyzer interface.

## Interface
- `NCORES`, 8: number of wavelet cores scanned (≥1).
- `ACC_W`, 12: signed accumulator and output word width (≥2).
- `FRAME_LEN`, 1024: enabled cycles per integration frame (≥2).
- `CORE_W` (localparam) = max(1, clog2(NCORES)).
- `clk_master` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ud_en` in 1: integration enable, common to all cores.
- `read_out_I` in 2*NCORES: core k uses bits [2k+1:2k]; bit 2k = +1 event, bit 2k+1 = −1 event.
- `read_out_Q` in 2*NCORES: same encoding for the Q channel.
- `out_data` out ACC_W: signed count of the current word.
- `out_core` out CORE_W: core index of the current word.
- `out_q` out 1: 0 = I channel, 1 = Q channel.
- `out_last` out 1: high on the final word of a frame.
- `out_valid` out 1: word available.
- `out_ready` in 1: consumer accepts word when `out_valid & out_ready`.
- `frame_tick` out 1: one-cycle pulse, cycle after each frame end.
- `overrun` out 1: sticky; a frame ended while the previous one was still draining.

## Operation
- Per-sample delta per channel: 01 → +1, 10 → −1, 00 or 11 → 0.
- Frame counter and all 2*NCORES accumulators update only on edges with `ud_en`=1; with `ud_en`=0 they hold. Serializer runs regardless of `ud_en`.
- Frame end = edge with `ud_en`=1 and counter = FRAME_LEN−1. On that edge: counter ← 0; every accumulator ← 0; if serializer IDLE, shadow ← acc + delta (the final sample is included) and serializer → SEND; if serializer SEND, shadow unchanged, frame discarded, `overrun` ← 1.
- Serializer states: IDLE (`out_valid`=0) and SEND. In SEND the word index runs 0…2*NCORES−1 in order core0 I, core0 Q, core1 I, …; `out_core` = index/2, `out_q` = index[0], `out_data` = the shadow entry. The index advances on `out_valid & out_ready`; the handshake on the last index → IDLE.
- Outputs are stable while `out_valid` & !`out_ready`.
- A frame end on the same edge as the last-word handshake counts as IDLE: the new snapshot is taken, no overrun, SEND restarts at index 0.
- Arithmetic: two's complement, ACC_W bits; wrap on overflow (see Configuration).
- Reset (any time, including mid-frame or mid-drain): counter, accumulators, shadow, index, `out_valid`, `out_last`, `frame_tick`, `overrun` = 0; `out_data` = 0, `out_core` = 0, `out_q` = 0; state IDLE. `overrun` clears only on reset.

## Timing
- Latency: frame-end edge → `out_valid`=1 and `frame_tick`=1 in the following cycle (registered).
- Peak throughput: one word per cycle with `out_ready` held high; a full drain takes 2*NCORES cycles.
- There is no combinational path from inputs to outputs. `out_valid` does not depend on `out_ready` in the same cycle.
- Overrun-free operation requires that the consumer drain 2*NCORES words within FRAME_LEN enabled cycles.

## Configuration
- `READOUT_SATURATE_EN` defined: accumulators clamp at +2^(ACC_W−1)−1 and −2^(ACC_W−1); a delta that would cross a bound leaves the accumulator at that bound.
- Not defined: accumulators wrap modulo 2^ACC_W.

## Test plan
- Bench parameters: NCORES=2, ACC_W=4, FRAME_LEN=8.
- Constant core0 I=01, core1 Q=10, all others 00, `ud_en`=1, `out_ready`=1 → after 8 cycles, words in order (0,I,+8 wraps to −8 / saturated +7), (0,Q,0), (1,I,0), (1,Q,−8), with `out_last` on word 4 and `frame_tick` one pulse.
- Core0 I alternating 01/11/10/00 for 8 enabled cycles → core0 I word = 0, no `overrun`.
- `ud_en` low for 5 cycles mid-frame with core0 I=01 → those cycles are not counted; frame end is delayed 5 cycles and the count is unchanged.
- `out_ready`=0 across two frame ends → `overrun`=1 after the second; the first frame's words are presented unchanged when `out_ready` rises.
- Assert `rst` during the third word of a drain → all outputs 0 next edge, IDLE; the next frame starts from count 0.
